// File: rtl/nic_out_vc_manager.sv
// Per-VC state, owner and credit tracking for one NIC output port.
// A VC is handed back to the allocator only after its tail has left and
// every downstream slot has been returned, so packets never share a VC.
module nic_out_vc_manager #(
  parameter int unsigned N_OF_REQUEST        = 6,
  parameter int unsigned N_BITS_N_OF_REQUEST = 3,
  parameter int unsigned N_OF_VC             = 2,
  parameter int unsigned BUFFER_DEPTH        = 4,
  parameter int unsigned N_BITS_CREDIT       = 3
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [N_OF_REQUEST*N_OF_VC-1:0]        g_vc_i,
  input  logic [N_OF_VC-1:0]                     flit_sent_i,
  input  logic [N_OF_VC-1:0]                     tail_sent_i,
  input  logic [N_OF_VC-1:0]                     credit_in_i,
  output logic [N_OF_VC-1:0]                     vc_free_o,
  output logic [N_OF_VC*N_BITS_N_OF_REQUEST-1:0] vc_owner_o,
  output logic [N_OF_VC*N_BITS_CREDIT-1:0]       credit_cnt_o,
  output logic [N_OF_VC-1:0]                     credit_avail_o,
  output logic                                   error_o
);

  typedef enum logic [1:0] {StFree, StActive, StDrain} vc_state_e;

  localparam logic [N_BITS_CREDIT-1:0] FullCnt = N_BITS_CREDIT'(BUFFER_DEPTH);

  vc_state_e                      state_q [N_OF_VC];
  vc_state_e                      state_d [N_OF_VC];
  logic [N_BITS_CREDIT-1:0]       cnt_q   [N_OF_VC];
  logic [N_BITS_CREDIT-1:0]       cnt_d   [N_OF_VC];
  logic [N_BITS_N_OF_REQUEST-1:0] owner_q [N_OF_VC];
  logic [N_BITS_N_OF_REQUEST-1:0] owner_d [N_OF_VC];
  logic                           error_q, error_d;

  logic [N_OF_VC-1:0]             grant_hit;
  logic [N_OF_VC-1:0]             grant_multi;
  logic [N_BITS_N_OF_REQUEST-1:0] grant_sel [N_OF_VC];

  // Per VC: find the lowest requester granted and flag contention.
  always_comb begin
    for (int v = 0; v < N_OF_VC; v++) begin
      grant_hit[v]   = 1'b0;
      grant_multi[v] = 1'b0;
      grant_sel[v]   = '0;
      for (int r = 0; r < N_OF_REQUEST; r++) begin
        if (g_vc_i[r*N_OF_VC+v]) begin
          if (!grant_hit[v]) begin
            grant_hit[v] = 1'b1;
            grant_sel[v] = N_BITS_N_OF_REQUEST'(r);
          end else begin
            grant_multi[v] = 1'b1;
          end
        end
      end
    end
  end

  // Next state, owner, counter and error flag; illegal actions are dropped.
  always_comb begin
    logic flit_ok, inc, dec;
    error_d = error_q;
    for (int v = 0; v < N_OF_VC; v++) begin
      state_d[v] = state_q[v];
      cnt_d[v]   = cnt_q[v];
      owner_d[v] = owner_q[v];

      flit_ok = flit_sent_i[v] && (state_q[v] == StActive);
      inc     = credit_in_i[v] && (cnt_q[v] != FullCnt);
      // A flit at zero credit is only accounted if a credit arrives with it.
      dec     = flit_ok && ((cnt_q[v] != '0) || credit_in_i[v]);

      if (grant_multi[v]) error_d = 1'b1;
      if (grant_hit[v] && (state_q[v] != StFree)) error_d = 1'b1;
      if (flit_sent_i[v] && (state_q[v] != StActive)) error_d = 1'b1;
      if (flit_ok && (cnt_q[v] == '0) && !credit_in_i[v]) error_d = 1'b1;
      if (credit_in_i[v] && (cnt_q[v] == FullCnt)) error_d = 1'b1;
      if (tail_sent_i[v] && !flit_sent_i[v]) error_d = 1'b1;

      if (inc && !dec) begin
        cnt_d[v] = cnt_q[v] + N_BITS_CREDIT'(1);
      end else if (dec && !inc) begin
        cnt_d[v] = cnt_q[v] - N_BITS_CREDIT'(1);
      end

      case (state_q[v])
        StFree: begin
          if (grant_hit[v]) begin
            state_d[v] = StActive;
            owner_d[v] = grant_sel[v];
          end
        end
        StActive: begin
          if (flit_ok && tail_sent_i[v]) state_d[v] = StDrain;
        end
        StDrain: begin
          if (cnt_q[v] == FullCnt) state_d[v] = StFree;
        end
        default: state_d[v] = StFree;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      error_q <= 1'b0;
      for (int v = 0; v < N_OF_VC; v++) begin
        state_q[v] <= StFree;
        cnt_q[v]   <= FullCnt;
        owner_q[v] <= '0;
      end
    end else begin
      error_q <= error_d;
      for (int v = 0; v < N_OF_VC; v++) begin
        state_q[v] <= state_d[v];
        cnt_q[v]   <= cnt_d[v];
        owner_q[v] <= owner_d[v];
      end
    end
  end

  // Output decodes and flattening.
  always_comb begin
    error_o = error_q;
    for (int v = 0; v < N_OF_VC; v++) begin
      vc_free_o[v]      = (state_q[v] == StFree);
      credit_avail_o[v] = (state_q[v] == StActive) && (cnt_q[v] != '0);
      vc_owner_o[v*N_BITS_N_OF_REQUEST +: N_BITS_N_OF_REQUEST] = owner_q[v];
      credit_cnt_o[v*N_BITS_CREDIT +: N_BITS_CREDIT]            = cnt_q[v];
    end
  end

endmodule

// File: doc/nic_out_vc_manager.md
# nic_out_vc_manager

Tracks the state, ownership and downstream credits of every virtual channel (VC) on one NIC output port. It produces the `vc_free` vector consumed by the VN allocator and absorbs that allocator's VC grants. It also follows flit departures and credit returns, and releases a VC only after its packet's tail has left and the downstream buffer has fully drained (atomic VC reuse). It sits between the N-to-1 VN allocator and the output link / flit switch of the NIC.

## Interface
- N_OF_REQUEST, 6, number of requesters that can be granted a VC
- N_BITS_N_OF_REQUEST, 3, width of a requester index
- N_OF_VC, 2, VCs on the output port
- BUFFER_DEPTH, 4, downstream buffer slots per VC (initial credits)
- N_BITS_CREDIT, 3, credit counter width; must hold BUFFER_DEPTH
---
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- g_vc_i  in  N_OF_REQUEST*N_OF_VC  allocator grants; bit r*N_OF_VC+v = requester r granted VC v
- flit_sent_i  in  N_OF_VC  one flit leaves on VC v this cycle
- tail_sent_i  in  N_OF_VC  the flit leaving on VC v is a tail; meaningful only with flit_sent_i[v]
- credit_in_i  in  N_OF_VC  one credit returned from downstream for VC v
- vc_free_o  out  N_OF_VC  VC v is allocatable (to allocator vc_free_i)
- vc_owner_o  out  N_OF_VC*N_BITS_N_OF_REQUEST  requester index owning VC v
- credit_cnt_o  out  N_OF_VC*N_BITS_CREDIT  current credit count per VC
- credit_avail_o  out  N_OF_VC  VC v is ACTIVE and has credit != 0 (may send a flit)
- error_o  out  1  sticky protocol-violation flag

## Operation
- Per-VC FSM, states FREE, ACTIVE, DRAIN; one credit counter and one owner register per VC.
- FREE -> ACTIVE: when any grant bit targets VC v. Owner is latched as the requester index r. If several requesters target the same VC, the lowest r wins and error_o is set.
- ACTIVE -> DRAIN: flit_sent_i[v] & tail_sent_i[v].
- DRAIN -> FREE: registered counter of v == BUFFER_DEPTH.
- Counter update, evaluated per cycle: +1 on credit_in_i, -1 on flit_sent_i. Simultaneous credit_in and flit_sent leave the counter unchanged and are legal, provided the error rules below allow both.
- Error cases. In each case error_o is set and the offending action is ignored; all other activity proceeds normally.
  - Grant to a VC that is not FREE: the grant is ignored.
  - flit_sent_i on a VC not ACTIVE: the counter and state are unchanged.
  - flit_sent_i when the counter is 0 with no simultaneous credit_in: the counter is not decremented. A tail still moves the VC to DRAIN.
  - credit_in_i when the counter == BUFFER_DEPTH: the counter is not incremented.
  - tail_sent_i without flit_sent_i: ignored.
- Combinational output decodes: vc_free_o[v] = (state==FREE); credit_avail_o[v] = (state==ACTIVE) & (counter!=0).
- vc_owner_o holds its value through ACTIVE and DRAIN. It keeps its last value in FREE.
- Reset values: all states FREE, counters = BUFFER_DEPTH, owners 0, error_o 0. So vc_free_o is all ones, credit_avail_o is 0, and credit_cnt_o = BUFFER_DEPTH per VC.
- Reset asserted mid-packet: all VCs return to FREE with full credit on the next edge, regardless of traffic on that cycle.

## Timing
- Grant at cycle t: state ACTIVE and vc_free_o[v]=0 at t+1; owner visible at t+1.
- A grant and a flit_sent_i on the same FREE VC in the same cycle: the flit is an error, and the grant is still taken.
- flit/credit at cycle t: credit_cnt_o and credit_avail_o reflect the update at t+1.
- Tail at t: DRAIN at t+1, credit_avail_o=0 at t+1.
- A credit making the counter full at t: the counter is full at t+1, FREE at t+2, vc_free_o=1 at t+2.
- Minimum VC reuse for a 1-flit packet, with the credit returned immediately: grant t, flit+tail t+1, credit t+2, FREE t+4.
- VCs are fully independent. All VCs may change state in the same cycle.

## Test plan
- Reset: assert rst for 2 cycles -> vc_free_o=2'b11, credit_cnt_o={3'd4,3'd4}, credit_avail_o=0, error_o=0.
- Single packet: grant requester 3 on VC1, then 3 flits on VC1 with tail on the 3rd, then 3 credits one per cycle.
  - Required response: vc_owner_o[VC1]=3; count 4->3->2->1; DRAIN after the tail; FREE exactly 2 cycles after the 3rd credit; error_o=0.
- Credit exhaustion: send 4 flits without credits -> counter 0, credit_avail_o[0]=0. Then a 5th flit -> error_o=1 and the counter stays 0.
- Simultaneous flit_sent and credit_in on VC0 at count 2 -> count stays 2, no error.
- Grant to a busy VC: grant VC0 to requester 1, then grant VC0 to requester 4 while ACTIVE -> owner stays 1, error_o=1.
- Reset mid-packet with VC0 ACTIVE at count 1 -> next cycle FREE, count 4, error_o=0.
